// File: rtl/matrix_stream_packer.sv
// matrix_stream_packer: buffers matrix strobe events in a FIFO and serialises
// them into a tagged byte stream on a valid/ready byte port.
module matrix_stream_packer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  TAG_ELEM   = 8'h01,
    parameter logic [7:0]  TAG_ROW    = 8'h02,
    parameter logic [7:0]  TAG_END    = 8'h03
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_matrix_en,
    input  logic [15:0]                  in_matrix,
    input  logic                         in_matrix_end_row,
    input  logic                         in_matrix_end,
    output logic [7:0]                   out_byte,
    output logic                         out_byte_valid,
    input  logic                         out_byte_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         overflow,
    output logic                         busy
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = 19;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] E_TAG = 3'd1;
    localparam logic [2:0] E_HI  = 3'd2;
    localparam logic [2:0] E_LO  = 3'd3;
    localparam logic [2:0] R_TAG = 3'd4;
    localparam logic [2:0] M_TAG = 3'd5;

    // Entry layout: [18]=element, [17]=end_row, [16]=end, [15:0]=data
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] wr_entry;
    logic               empty;
    logic               full;
    logic               push_req;
    logic               push_ok;
    logic               pop;
    logic [LVL_W-1:0]   level_next;

    logic [2:0]         state;
    logic [2:0]         state_next;
    logic [7:0]         byte_next;
    logic               valid_next;
    logic               accept;
    logic [2:0]         hold_flags;
    logic [15:0]        hold_data;
    logic [15:0]        src_data;

    assign head     = mem[rd_ptr];
    assign empty    = (fifo_level == '0);
    assign full     = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign push_req = in_matrix_en | in_matrix_end_row | in_matrix_end;
    assign push_ok  = push_req & (~full | pop);
    assign wr_entry = {in_matrix_en, in_matrix_end_row, in_matrix_end,
                       in_matrix_en ? in_matrix : 16'h0000};
    assign accept   = out_byte_valid & out_byte_ready;

    // Occupancy after this cycle's push/pop
    always_comb begin
        level_next = fifo_level;
        case ({push_ok, pop})
            2'b10:   level_next = fifo_level + LVL_W'(1);
            2'b01:   level_next = fifo_level - LVL_W'(1);
            default: level_next = fifo_level;
        endcase
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // FIFO pointers, level and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_level <= level_next;
            if (push_req && full && !pop) overflow <= 1'b1;
        end
    end

    // Next state and next registered byte; an entry's flags are walked in order
    always_comb begin
        state_next = state;
        byte_next  = out_byte;
        valid_next = out_byte_valid;
        pop        = 1'b0;
        src_data   = hold_data;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    src_data = head[15:0];
                    if (head[18])      state_next = E_TAG;
                    else if (head[17]) state_next = R_TAG;
                    else               state_next = M_TAG;
                end
            end
            E_TAG: if (accept) state_next = E_HI;
            E_HI:  if (accept) state_next = E_LO;
            E_LO: begin
                if (accept) begin
                    if (hold_flags[1])      state_next = R_TAG;
                    else if (hold_flags[0]) state_next = M_TAG;
                    else                    state_next = IDLE;
                end
            end
            R_TAG: begin
                if (accept) state_next = hold_flags[0] ? M_TAG : IDLE;
            end
            M_TAG: if (accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (state_next != state) begin
            valid_next = (state_next != IDLE);
            case (state_next)
                E_TAG:   byte_next = TAG_ELEM;
                E_HI:    byte_next = src_data[15:8];
                E_LO:    byte_next = src_data[7:0];
                R_TAG:   byte_next = TAG_ROW;
                M_TAG:   byte_next = TAG_END;
                default: byte_next = out_byte;
            endcase
        end
    end

    // FSM state, holding register and registered byte port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            out_byte       <= 8'h00;
            out_byte_valid <= 1'b0;
            hold_flags     <= 3'b000;
            hold_data      <= 16'h0000;
            busy           <= 1'b0;
        end else begin
            state          <= state_next;
            out_byte       <= byte_next;
            out_byte_valid <= valid_next;
            busy           <= (level_next != '0) | (state_next != IDLE);
            if (pop) begin
                hold_flags <= head[18:16];
                hold_data  <= head[15:0];
            end
        end
    end

endmodule

// File: tb/tb_matrix_stream_packer.sv
// Directed self-checking bench for matrix_stream_packer.
module tb_matrix_stream_packer;

    logic        clk;
    logic        reset;
    logic        in_matrix_en;
    logic [15:0] in_matrix;
    logic        in_matrix_end_row;
    logic        in_matrix_end;
    logic [7:0]  out_byte;
    logic        out_byte_valid;
    logic        out_byte_ready;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    matrix_stream_packer dut (
        .clk               (clk),
        .reset             (reset),
        .in_matrix_en      (in_matrix_en),
        .in_matrix         (in_matrix),
        .in_matrix_end_row (in_matrix_end_row),
        .in_matrix_end     (in_matrix_end),
        .out_byte          (out_byte),
        .out_byte_valid    (out_byte_valid),
        .out_byte_ready    (out_byte_ready),
        .fifo_level        (fifo_level),
        .overflow          (overflow),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every byte that will be accepted at the next rising edge
    always @(negedge clk) begin
        if (!reset && out_byte_valid && out_byte_ready) got.push_back(out_byte);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic row, input logic last, input logic [15:0] data);
        in_matrix_en      = en;
        in_matrix_end_row = row;
        in_matrix_end     = last;
        in_matrix         = data;
    endtask

    task automatic send(input logic en, input logic row, input logic last, input logic [15:0] data);
        drive(en, row, last, data);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int c = 0;
        while (got.size() < n && c < budget) begin
            tick();
            c++;
        end
        check(tag, 32'(got.size()), 32'(n));
    endtask

    task automatic check_stream(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            check(tag, (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(exp_q[i]));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        reset          = 1'b1;
        out_byte_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        do_reset();

        // Reset state
        check("rst_byte",  32'(out_byte), 32'h00);
        check("rst_valid", 32'(out_byte_valid), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        check("rst_ovf",   32'(overflow), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);

        // 1: single element, latency and bytes
        out_byte_ready = 1'b1;
        send(1'b1, 1'b0, 1'b0, 16'h1234);
        check("t1_valid_n1", 32'(out_byte_valid), 32'h0);
        check("t1_level_n1", 32'(fifo_level), 32'h1);
        tick();
        check("t1_valid_n2", 32'(out_byte_valid), 32'h1);
        check("t1_byte_n2",  32'(out_byte), 32'h01);
        wait_bytes("t1_count", 3, 20);
        exp_q = '{8'h01, 8'h12, 8'h34};
        check_stream("t1_stream");
        tick();
        check("t1_busy", 32'(busy), 32'h0);

        // 2: all three flags in one cycle
        got.delete();
        send(1'b1, 1'b1, 1'b1, 16'hBEEF);
        check("t2_level", 32'(fifo_level), 32'h1);
        wait_bytes("t2_count", 5, 30);
        exp_q = '{8'h01, 8'hBE, 8'hEF, 8'h02, 8'h03};
        check_stream("t2_stream");
        tick();
        check("t2_level_end", 32'(fifo_level), 32'h0);
        check("t2_busy", 32'(busy), 32'h0);

        // 3: backpressure holds the tag byte stable
        got.delete();
        out_byte_ready = 1'b0;
        send(1'b1, 1'b0, 1'b0, 16'h00FF);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", 32'(out_byte_valid), 32'h1);
            check("t3_hold_byte",  32'(out_byte), 32'h01);
            tick();
        end
        out_byte_ready = 1'b1;
        wait_bytes("t3_count", 3, 20);
        exp_q = '{8'h01, 8'h00, 8'hFF};
        check_stream("t3_stream");

        // 4: FSM stalled on an end-of-row entry, then 17 elements overfill the FIFO
        do_reset();
        out_byte_ready = 1'b0;
        send(1'b0, 1'b1, 1'b0, 16'h0000);
        tick();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 1'b0, 16'hA000 + 16'(i));
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        check("t4_level", 32'(fifo_level), 32'd16);
        check("t4_ovf",   32'(overflow), 32'h1);
        out_byte_ready = 1'b1;
        wait_bytes("t4_count", 49, 300);
        exp_q.delete();
        exp_q.push_back(8'h02);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'h01);
            exp_q.push_back(8'hA0);
            exp_q.push_back(8'(i));
        end
        check_stream("t4_stream");
        for (int i = 0; i < 8; i++) tick();
        check("t4_no_extra", 32'(got.size()), 32'd49);
        check("t4_ovf_sticky", 32'(overflow), 32'h1);
        check("t4_busy", 32'(busy), 32'h0);

        // 5: write to a full FIFO on the same cycle as a pop
        do_reset();
        out_byte_ready = 1'b0;
        send(1'b0, 1'b1, 1'b0, 16'h0000);
        tick();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 1'b0, 16'hB000 + 16'(i));
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        check("t5_level_full", 32'(fifo_level), 32'd16);
        check("t5_ovf_pre",    32'(overflow), 32'h0);
        out_byte_ready = 1'b1;
        tick();
        check("t5_idle_valid", 32'(out_byte_valid), 32'h0);
        send(1'b1, 1'b0, 1'b0, 16'hC0DE);
        check("t5_level_pop", 32'(fifo_level), 32'd16);
        check("t5_ovf_pop",   32'(overflow), 32'h0);
        wait_bytes("t5_count", 52, 300);
        exp_q.delete();
        exp_q.push_back(8'h02);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'h01);
            exp_q.push_back(8'hB0);
            exp_q.push_back(8'(i));
        end
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hDE);
        check_stream("t5_stream");

        // 6: reset while sending the high data byte
        do_reset();
        out_byte_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 16'h5678);
        tick();
        drive(1'b1, 1'b0, 1'b0, 16'h1111);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        check("t6_mid_byte",  32'(out_byte), 32'h56);
        check("t6_mid_level", 32'(fifo_level), 32'h1);
        reset = 1'b1;
        #1;
        check("t6_rst_valid", 32'(out_byte_valid), 32'h0);
        check("t6_rst_level", 32'(fifo_level), 32'h0);
        check("t6_rst_ovf",   32'(overflow), 32'h0);
        check("t6_rst_busy",  32'(busy), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        got.delete();
        send(1'b1, 1'b0, 1'b0, 16'h9ABC);
        wait_bytes("t6_count", 3, 20);
        exp_q = '{8'h01, 8'h9A, 8'hBC};
        check_stream("t6_stream");
        for (int i = 0; i < 6; i++) tick();
        check("t6_no_extra", 32'(got.size()), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
